// File: rtl/ipml_prefetch_fifo_wr_adapter.sv
// ---------------------------------------------------------------------------
// ipml_prefetch_fifo_wr_adapter
//
// Write-side front end for the prefetch FIFO. Upstream beats arrive on a
// valid/ready stream and are written to the FIFO write port (wr_en/wr_data)
// when the FIFO is not full. A 2-entry register skid buffer (head H, tail T)
// sits in between, so data_in_ready is computed from flops only and never
// depends combinationally on fifo_wr_full.
//
// Optional feature macro: IPML_WR_ADAPTER_CNT_EN
//   When defined, adds the wr_beat_cnt output, a registered count of FIFO
//   writes that wraps modulo 2^CNT_W. When undefined, the port and counter
//   are absent.
//
// Parameters
//   W      data width (1..1152)
//   CNT_W  width of the optional write-beat counter (2..32)
//
// Ports
//   clk            in   single clock, all logic on posedge
//   rst_n          in   asynchronous active-low reset
//   data_in_valid  in   upstream beat valid
//   data_in        in   upstream beat data [W-1:0]
//   data_in_ready  out  adapter accepts a beat this cycle
//   fifo_wr_en     out  FIFO write strobe, one beat per high cycle
//   fifo_wr_data   out  FIFO write data (head entry) [W-1:0]
//   fifo_wr_full   in   FIFO full flag
//   occupancy      out  skid entries held: 0, 1 or 2
//   wr_beat_cnt    out  write-beat counter [CNT_W-1:0] (macro only)
// ---------------------------------------------------------------------------
module ipml_prefetch_fifo_wr_adapter #(
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_in_valid,
  input  logic [W-1:0]     data_in,
  output logic             data_in_ready,
  output logic             fifo_wr_en,
  output logic [W-1:0]     fifo_wr_data,
  input  logic             fifo_wr_full,
  output logic [1:0]       occupancy
`ifdef IPML_WR_ADAPTER_CNT_EN
  ,
  output logic [CNT_W-1:0] wr_beat_cnt
`endif
);

  // Elaboration-time guard on the legal parameter ranges.
  if ((W < 1) || (W > 1152) || (CNT_W < 2) || (CNT_W > 32)) begin : g_param_check
    $error("ipml_prefetch_fifo_wr_adapter: parameter out of range");
  end

  // The state encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   head_q, head_d;
  logic [W-1:0]   tail_q, tail_d;
  logic           rdy_en_q, rdy_en_d;
  logic           push;
  logic           pop;

`ifdef IPML_WR_ADAPTER_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Ready depends only on flops: the run-enable flop and the skid state.
  // rdy_en_q holds ready low for the first cycle after reset release.
  assign data_in_ready = rdy_en_q & (state_q != TWO);
  assign fifo_wr_en    = (state_q != EMPTY) & ~fifo_wr_full;
  assign fifo_wr_data  = head_q;
  assign occupancy     = state_q;

  assign push = data_in_valid & data_in_ready;
  assign pop  = fifo_wr_en;

  // Skid-buffer next state. The head entry is always the oldest beat; when
  // the head is written out of a full buffer the tail slides into it.
  always_comb begin
    state_d  = state_q;
    head_d   = head_q;
    tail_d   = tail_q;
    rdy_en_d = 1'b1;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          head_d  = data_in;
        end
      end
      ONE: begin
        if (push && !pop) begin
          state_d = TWO;
          tail_d  = data_in;
        end else if (!push && pop) begin
          state_d = EMPTY;
        end else if (push && pop) begin
          head_d  = data_in;
        end
      end
      TWO: begin
        if (pop) begin
          state_d = ONE;
          head_d  = tail_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

`ifdef IPML_WR_ADAPTER_CNT_EN
  // Counts FIFO writes; wraps naturally at 2^CNT_W.
  always_comb begin
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, pop};
  end

  assign wr_beat_cnt = cnt_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      head_q   <= '0;
      tail_q   <= '0;
      rdy_en_q <= 1'b0;
`ifdef IPML_WR_ADAPTER_CNT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      rdy_en_q <= rdy_en_d;
`ifdef IPML_WR_ADAPTER_CNT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

endmodule
